issue_scoreboard: RTL and testbench
===================================

# issue_scoreboard

Issue controller between DECODE and the execute stage of the tinyriscv core. It holds one decoded instruction at the decode/execute boundary until its operands and destination are free. It serialises control-flow and memory instructions and passes the instruction on with a valid/ready handshake. A 32-entry pending-write scoreboard is maintained from issue and writeback events.

## Interface
- MAX_INFLIGHT, default 4: maximum number of issued, not-yet-written-back register-writing instructions (1..15).
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  decoded instruction present
- in_ready  out  1  instruction accepted this cycle (combinational)
- in_insttype  in  2  00 AL, 01 BR, 10 AG (11 treated as AL)
- in_rs, in_rt, in_rd  in  5 each  source/destination register addresses
- in_rs_v, in_rt_v  in  1 each  source valid
- in_rfwe  in  1  instruction writes rd
- issue_valid  out  1  instruction offered to execute (combinational)
- issue_ready  in  1  execute can accept
- wb_valid  in  1  register writeback this cycle
- wb_rd  in  5  writeback destination
- br_done  in  1  branch/jump resolved in execute
- mem_done  in  1  memory access complete
- inflight  out  4  current pending-write count
- wb_err  out  1  sticky; writeback to a non-pending register seen

## Operation
- pend[31:0]: bit r is set while a write to xr is outstanding. pend[0] is never set.
- hazard is the OR of:
  - raw: (in_rs_v & pend[in_rs]) | (in_rt_v & pend[in_rt]);
  - waw: in_rfwe & in_rd≠0 & pend[in_rd];
  - full: in_rfwe & in_rd≠0 & inflight==MAX_INFLIGHT;
  - memb: in_insttype==10 & mem_busy.
- States: RUN, BR_WAIT.
- Outputs:
  - issue_valid = in_valid & RUN & ~hazard.
  - in_ready = issue_valid & issue_ready.
- Fire = in_ready. On fire:
  - if in_rfwe & in_rd≠0: set pend[in_rd] and increment inflight;
  - if AG: set mem_busy;
  - if BR: go to BR_WAIT.
- BR_WAIT: no issue. br_done returns the state to RUN next cycle. br_done in RUN is ignored.
- Writeback: wb_valid & wb_rd≠0 & pend[wb_rd] clears the bit and decrements inflight. wb_valid to a non-pending, non-zero register sets wb_err, and pend and inflight are unchanged. wb_rd==0 is ignored.
- mem_done clears mem_busy. mem_done while not busy is ignored.
- Simultaneous events:
  - Fire with writeback to a different register: inflight is net unchanged.
  - Fire setting and writeback clearing the same register in one cycle: the set wins. This is reachable only with bypass (see Configuration).
  - mem_done with an AG fire: mem_busy stays 1.
  - br_done in the cycle a BR fires: ignored; the state still enters BR_WAIT.
- Reset mid-operation clears all state regardless of in-flight work. Upstream and downstream stages are reset together.

## Timing
- Zero-latency pass-through: issue_valid and in_ready are combinational from inputs and state.
- Scoreboard, state, mem_busy, inflight and wb_err update at the rising edge after the event.
- Effect of a writeback on hazards is visible the cycle after wb_valid (without bypass).
- A dependent instruction issues at earliest 1 cycle after its producer's writeback cycle.
- Reset values: pend=0, inflight=0, state=RUN, mem_busy=0, wb_err=0. Outputs with in_valid=0 are issue_valid=0 and in_ready=0.

## Configuration
- ISSUE_WB_BYPASS_EN defined:
  - raw and waw terms ignore any register equal to wb_rd when wb_valid & wb_rd≠0 in the same cycle;
  - full is evaluated against inflight minus that writeback.
  - A dependent instruction can then issue in the writeback cycle.
- Undefined: hazards use the registered pend and inflight only; one-cycle writeback-to-issue gap.

## Test plan
- Reset, then `addi x5` (rfwe, rd=5) with issue_ready=1 → issue_valid=1 in the same cycle; next cycle pend[5]=1, inflight=1.
- `add x6,x5,x1` with pend[5]=1 → issue_valid=0.
  - Bypass undefined: wb_valid, wb_rd=5 → issue in the following cycle.
  - ISSUE_WB_BYPASS_EN defined: issue in the wb cycle.
- `beq` fires → BR_WAIT; next in_valid AL instruction held with issue_valid=0 for 3 cycles; br_done → issues the cycle after.
- `lw` fires then `sw` presented → stalled until mem_done; `sw` fires the next cycle with mem_busy=1.
- MAX_INFLIGHT=4: issue writes to x1..x4, fifth to x7 → stall; wb to x2 → x7 issues next cycle, inflight=4.
- wb_valid to x9 with pend[9]=0 → wb_err=1 and sticky; rst_n low asynchronously → all outputs and state reset immediately.

Source files
------------

// File: rtl/issue_scoreboard.sv
// Issue controller with a 32-entry pending-write scoreboard between decode and execute.
// Optional same-cycle writeback bypass of hazards: define ISSUE_WB_BYPASS_EN.
module issue_scoreboard #(
  parameter int MAX_INFLIGHT = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [1:0] in_insttype,
  input  logic [4:0] in_rs,
  input  logic [4:0] in_rt,
  input  logic [4:0] in_rd,
  input  logic       in_rs_v,
  input  logic       in_rt_v,
  input  logic       in_rfwe,
  output logic       issue_valid,
  input  logic       issue_ready,
  input  logic       wb_valid,
  input  logic [4:0] wb_rd,
  input  logic       br_done,
  input  logic       mem_done,
  output logic [3:0] inflight,
  output logic       wb_err
);

  typedef enum logic {RUN, BR_WAIT} state_t;

  localparam logic [3:0] MAX_CNT = 4'(MAX_INFLIGHT);

  state_t      state, state_nxt;
  logic [31:0] pend, pend_nxt, pend_eff;
  logic [3:0]  inflight_nxt, inflight_eff;
  logic        mem_busy, mem_busy_nxt;
  logic        wb_err_nxt;
  logic        wb_nz, wb_hit, wb_miss;
  logic        rd_wr, is_br, is_ag;
  logic        raw, waw, full, memb, hazard, fire;

  assign wb_nz   = wb_valid && (wb_rd != 5'd0);
  assign wb_hit  = wb_nz && pend[wb_rd];
  assign wb_miss = wb_nz && !pend[wb_rd];
  assign rd_wr   = in_rfwe && (in_rd != 5'd0);
  assign is_br   = (in_insttype == 2'b01);
  assign is_ag   = (in_insttype == 2'b10);

`ifdef ISSUE_WB_BYPASS_EN
  // A register being written back this cycle no longer blocks its consumers.
  assign pend_eff     = wb_nz ? (pend & ~(32'd1 << wb_rd)) : pend;
  assign inflight_eff = inflight - {3'd0, wb_hit};
`else
  assign pend_eff     = pend;
  assign inflight_eff = inflight;
`endif

  assign raw    = (in_rs_v && pend_eff[in_rs]) || (in_rt_v && pend_eff[in_rt]);
  assign waw    = rd_wr && pend_eff[in_rd];
  assign full   = rd_wr && (inflight_eff == MAX_CNT);
  assign memb   = is_ag && mem_busy;
  assign hazard = raw || waw || full || memb;

  assign issue_valid = in_valid && (state == RUN) && !hazard;
  assign in_ready    = issue_valid && issue_ready;
  assign fire        = in_ready;

  always_comb begin
    state_nxt    = state;
    pend_nxt     = pend;
    inflight_nxt = inflight;
    mem_busy_nxt = mem_busy;
    wb_err_nxt   = wb_err || wb_miss;
    // Clear before set so an issue to the register being retired wins.
    if (wb_hit) pend_nxt[wb_rd] = 1'b0;
    if (fire && rd_wr) pend_nxt[in_rd] = 1'b1;
    inflight_nxt = inflight + {3'd0, fire && rd_wr} - {3'd0, wb_hit};
    if (fire && is_ag)  mem_busy_nxt = 1'b1;
    else if (mem_done)  mem_busy_nxt = 1'b0;
    case (state)
      RUN:     if (fire && is_br) state_nxt = BR_WAIT;
      BR_WAIT: if (br_done)       state_nxt = RUN;
      default:                    state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RUN;
      pend     <= 32'd0;
      inflight <= 4'd0;
      mem_busy <= 1'b0;
      wb_err   <= 1'b0;
    end else begin
      state    <= state_nxt;
      pend     <= pend_nxt;
      inflight <= inflight_nxt;
      mem_busy <= mem_busy_nxt;
      wb_err   <= wb_err_nxt;
    end
  end

endmodule

// File: tb/tb_issue_scoreboard.sv
// Directed bench for issue_scoreboard: hazards, branch/memory serialisation, writeback errors, reset.
module tb_issue_scoreboard;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ready;
  logic [1:0] in_insttype;
  logic [4:0] in_rs, in_rt, in_rd;
  logic       in_rs_v, in_rt_v, in_rfwe;
  logic       issue_valid, issue_ready;
  logic       wb_valid;
  logic [4:0] wb_rd;
  logic       br_done, mem_done;
  logic [3:0] inflight;
  logic       wb_err;

  int errors = 0;
  int checks = 0;

`ifdef ISSUE_WB_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  always #5 clk = ~clk;

  issue_scoreboard #(.MAX_INFLIGHT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_insttype(in_insttype),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .in_rs_v(in_rs_v), .in_rt_v(in_rt_v), .in_rfwe(in_rfwe),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .wb_valid(wb_valid), .wb_rd(wb_rd),
    .br_done(br_done), .mem_done(mem_done),
    .inflight(inflight), .wb_err(wb_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic inst(input logic [1:0] t, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic rsv, input logic rtv, input logic we);
    in_valid = 1'b1; in_insttype = t;
    in_rs = rs; in_rt = rt; in_rd = rd;
    in_rs_v = rsv; in_rt_v = rtv; in_rfwe = we;
  endtask

  task automatic wb(input logic [4:0] r);
    wb_valid = 1'b1; wb_rd = r;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_insttype = 2'b00;
    in_rs = 5'd0; in_rt = 5'd0; in_rd = 5'd0;
    in_rs_v = 1'b0; in_rt_v = 1'b0; in_rfwe = 1'b0;
    issue_ready = 1'b1; wb_valid = 1'b0; wb_rd = 5'd0;
    br_done = 1'b0; mem_done = 1'b0;
    #1;
    check("rst_inflight", inflight, 0);
    check("rst_wb_err", wb_err, 0);
    check("rst_issue_valid", issue_valid, 0);
    check("rst_in_ready", in_ready, 0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    // addi x5 issues immediately
    inst(2'b00, 5'd0, 5'd0, 5'd5, 1'b0, 1'b0, 1'b1); #1;
    check("addi_valid", issue_valid, 1);
    check("addi_ready", in_ready, 1);
    @(negedge clk); in_valid = 1'b0; #1;
    check("addi_inflight", inflight, 1);

    // add x6,x5,x1 waits on x5
    inst(2'b00, 5'd5, 5'd1, 5'd6, 1'b1, 1'b1, 1'b1); #1;
    check("raw_stall", issue_valid, 0);
    @(negedge clk); wb(5'd5); issue_ready = 1'b0; #1;
    check("raw_wb_cycle", issue_valid, BYP);
    @(negedge clk); wb_valid = 1'b0; #1;
    check("raw_after_wb", issue_valid, 1);
    check("raw_not_ready", in_ready, 0);
    check("raw_inflight0", inflight, 0);
    issue_ready = 1'b1; #1;
    check("raw_fire", in_ready, 1);
    @(negedge clk); in_valid = 1'b0; wb(5'd6); #1;
    check("x6_inflight", inflight, 1);
    @(negedge clk); wb_valid = 1'b0; #1;
    check("x6_retired", inflight, 0);

    // beq with a same-cycle br_done that must be ignored
    inst(2'b01, 5'd1, 5'd2, 5'd0, 1'b1, 1'b1, 1'b0); br_done = 1'b1; #1;
    check("beq_fire", issue_valid, 1);
    @(negedge clk); br_done = 1'b0;
    inst(2'b00, 5'd1, 5'd0, 5'd7, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      #1 check("br_wait_hold", issue_valid, 0);
      @(negedge clk);
    end
    br_done = 1'b1; #1;
    check("br_done_cycle", issue_valid, 0);
    @(negedge clk); br_done = 1'b0; #1;
    check("br_resume", issue_valid, 1);
    @(negedge clk); in_valid = 1'b0; wb(5'd7); #1;
    check("x7_inflight", inflight, 1);
    @(negedge clk); wb_valid = 1'b0; #1;
    check("x7_retired", inflight, 0);

    // lw then sw serialised on mem_busy
    inst(2'b10, 5'd1, 5'd0, 5'd8, 1'b1, 1'b0, 1'b1); #1;
    check("lw_fire", issue_valid, 1);
    @(negedge clk); inst(2'b10, 5'd1, 5'd2, 5'd0, 1'b1, 1'b1, 1'b0); wb(5'd8); #1;
    check("sw_stall", issue_valid, 0);
    @(negedge clk); wb_valid = 1'b0; mem_done = 1'b1; #1;
    check("sw_mem_done_cycle", issue_valid, 0);
    check("lw_retired", inflight, 0);
    @(negedge clk); #1;
    check("sw_fire_with_done", issue_valid, 1);
    @(negedge clk); mem_done = 1'b0; inst(2'b10, 5'd3, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0); #1;
    check("busy_kept", issue_valid, 0);
    @(negedge clk); mem_done = 1'b1; #1;
    check("busy_done_cycle", issue_valid, 0);
    @(negedge clk); mem_done = 1'b0; issue_ready = 1'b0; #1;
    check("ag_free_valid", issue_valid, 1);
    check("ag_free_noready", in_ready, 0);
    @(negedge clk); in_valid = 1'b0; issue_ready = 1'b1;

    // fill to MAX_INFLIGHT
    for (int r = 1; r <= 4; r++) begin
      inst(2'b00, 5'd0, 5'd0, 5'(r), 1'b0, 1'b0, 1'b1); #1;
      check("fill_issue", issue_valid, 1);
      @(negedge clk);
    end
    inst(2'b00, 5'd0, 5'd0, 5'd7, 1'b0, 1'b0, 1'b1); #1;
    check("full_inflight", inflight, 4);
    check("full_stall", issue_valid, 0);
    @(negedge clk); wb(5'd2); issue_ready = 1'b0; #1;
    check("full_wb_cycle", issue_valid, BYP);
    @(negedge clk); wb_valid = 1'b0; issue_ready = 1'b1; #1;
    check("full_after_wb", issue_valid, 1);
    check("full_inflight3", inflight, 3);
    @(negedge clk); inst(2'b00, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1); #1;
    check("x7_inflight4", inflight, 4);
    check("rd0_when_full", issue_valid, 1);
    @(negedge clk); in_valid = 1'b0; wb(5'd1); #1;
    check("rd0_no_count", inflight, 4);
    @(negedge clk); wb(5'd3); inst(2'b00, 5'd0, 5'd0, 5'd9, 1'b0, 1'b0, 1'b1); #1;
    check("pre_net_inflight", inflight, 3);
    check("x9_issue", issue_valid, 1);

    // writeback error handling
    @(negedge clk); in_valid = 1'b0; wb(5'd10); #1;
    check("net_unchanged", inflight, 3);
    check("wb_err_clear", wb_err, 0);
    @(negedge clk); wb(5'd0); #1;
    check("wb_err_set", wb_err, 1);
    check("wb_err_no_dec", inflight, 3);
    @(negedge clk); wb_valid = 1'b0; inst(2'b00, 5'd9, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0); #1;
    check("wb_err_sticky", wb_err, 1);
    check("wb0_ignored", inflight, 3);
    check("x9_raw", issue_valid, 0);

    // enter mem_busy and BR_WAIT, then reset asynchronously
    @(negedge clk); inst(2'b10, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0); #1;
    check("pre_rst_ag", issue_valid, 1);
    @(negedge clk); inst(2'b01, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0); #1;
    check("pre_rst_br", issue_valid, 1);
    @(negedge clk); in_valid = 1'b0; #2; rst_n = 1'b0; #1;
    check("arst_inflight", inflight, 0);
    check("arst_wb_err", wb_err, 0);
    check("arst_issue_valid", issue_valid, 0);
    check("arst_in_ready", in_ready, 0);
    @(negedge clk); rst_n = 1'b1;
    inst(2'b10, 5'd4, 5'd9, 5'd4, 1'b1, 1'b1, 1'b1); #1;
    check("post_rst_valid", issue_valid, 1);
    check("post_rst_ready", in_ready, 1);
    @(negedge clk); in_valid = 1'b0; #1;
    check("post_rst_inflight", inflight, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
